// File: rtl/x_trig_window_pkg.sv
// Shared widths and state encoding for the trigger-chain window stage.
package x_trig_window_pkg;

  localparam int unsigned MXWID  = 4;
  localparam int unsigned MXDEAD = 4;
  localparam int unsigned MXCNT  = 12;

  // One down-counter serves both the window and the dead-time phases
  localparam int unsigned MXTMR  = (MXWID > MXDEAD) ? MXWID : MXDEAD;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WINDOW = 2'd1,
    DEAD   = 2'd2
  } win_state_t;

endpackage

// File: rtl/x_sat_counter.sv
// Saturating event counter with synchronous clear taking priority over increment.
module x_sat_counter
  import x_trig_window_pkg::*;
#(
  parameter int unsigned W = MXCNT
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/x_trig_window.sv
// Turns each accepted trigger pulse into a width+1 clock window followed by a
// dead time; triggers arriving while busy are rejected and counted.
module x_trig_window
  import x_trig_window_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              trig_in,
  input  logic [MXWID-1:0]  width,
  input  logic [MXDEAD-1:0] deadtime,
  input  logic              cnt_clear,
  output logic              window_out,
  output logic              window_start,
  output logic              busy,
  output logic [MXCNT-1:0]  n_accepted,
  output logic [MXCNT-1:0]  n_rejected
);

  win_state_t              state_q, state_d;
  logic [MXTMR-1:0]        tmr_q, tmr_d;
  logic [MXDEAD-1:0]       dead_q, dead_d;
  logic                    accept;
  logic                    reject;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      tmr_q        <= '0;
      dead_q       <= '0;
      window_out   <= 1'b0;
      window_start <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      dead_q       <= dead_d;
      // Outputs are registered from the next state so they line up with it
      window_out   <= (state_d == WINDOW);
      window_start <= (state_q == IDLE) && (state_d == WINDOW);
      busy         <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    dead_d  = dead_q;
    accept  = 1'b0;
    reject  = 1'b0;
    case (state_q)
      IDLE: begin
        if (trig_in) begin
          accept  = 1'b1;
          tmr_d   = MXTMR'(width);
          dead_d  = deadtime;
          state_d = WINDOW;
        end
      end
      WINDOW: begin
        reject = trig_in;
        if (tmr_q == '0) begin
          if (dead_q != '0) begin
            tmr_d   = MXTMR'(dead_q) - MXTMR'(1);
            state_d = DEAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          tmr_d = tmr_q - MXTMR'(1);
        end
      end
      DEAD: begin
        reject = trig_in;
        if (tmr_q == '0) begin
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q - MXTMR'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  x_sat_counter #(.W(MXCNT)) u_acc_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (accept),
    .clear   (cnt_clear),
    .count   (n_accepted)
  );

  x_sat_counter #(.W(MXCNT)) u_rej_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (reject),
    .clear   (cnt_clear),
    .count   (n_rejected)
  );

endmodule

// File: tb/tb_x_trig_window.sv
// Directed bench for x_trig_window: vector table plus saturation/clear/reset sequences.
module tb_x_trig_window;
  import x_trig_window_pkg::*;

  logic              clock;
  logic              reset_n;
  logic              trig_in;
  logic [MXWID-1:0]  width;
  logic [MXDEAD-1:0] deadtime;
  logic              cnt_clear;
  logic              window_out;
  logic              window_start;
  logic              busy;
  logic [MXCNT-1:0]  n_accepted;
  logic [MXCNT-1:0]  n_rejected;

  int checks = 0;
  int errors = 0;

  x_trig_window dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .trig_in      (trig_in),
    .width        (width),
    .deadtime     (deadtime),
    .cnt_clear    (cnt_clear),
    .window_out   (window_out),
    .window_start (window_start),
    .busy         (busy),
    .n_accepted   (n_accepted),
    .n_rejected   (n_rejected)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        trig;
    logic [3:0]  w;
    logic [3:0]  d;
    logic        clr;
    logic        win;
    logic        st;
    logic        bsy;
    int          acc;
    int          rej;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic trig, input int w, input int d, input logic clr,
                     input logic win, input logic st, input logic bsy,
                     input int acc, input int rej);
    vec_t v;
    v.trig = trig; v.w = 4'(w); v.d = 4'(d); v.clr = clr;
    v.win = win; v.st = st; v.bsy = bsy; v.acc = acc; v.rej = rej;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic trig, input logic [3:0] w, input logic [3:0] d, input logic clr);
    trig_in = trig; width = MXWID'(w); deadtime = MXDEAD'(d); cnt_clear = clr;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    // Row r: outputs expected during cycle r, then inputs driven for cycle r.
    add(0,0,0,0, 0,0,0,0,0);
    add(1,3,0,0, 0,0,0,0,0);
    add(0,3,0,0, 1,1,1,1,0);
    for (int k = 0; k < 3; k++) add(0,3,0,0, 1,0,1,1,0);
    add(0,0,0,0, 0,0,0,1,0);
    add(1,2,4,0, 0,0,0,1,0);
    add(0,2,4,0, 1,1,1,2,0);
    add(0,2,4,0, 1,0,1,2,0);
    add(1,2,4,0, 1,0,1,2,0);
    for (int k = 0; k < 4; k++) add(0,2,4,0, 0,0,1,2,1);
    add(1,0,0,0, 0,0,0,2,1);
    add(0,0,0,0, 1,1,1,3,1);
    add(1,0,0,0, 0,0,0,3,1);
    add(0,0,0,0, 1,1,1,4,1);
    add(1,0,0,0, 0,0,0,4,1);
    add(0,0,0,0, 1,1,1,5,1);
    add(0,0,0,0, 0,0,0,5,1);
    add(1,0,0,0, 0,0,0,5,1);
    add(1,0,0,0, 1,1,1,6,1);
    add(0,0,0,0, 0,0,0,6,2);
    add(1,3,0,0, 0,0,0,6,2);
    add(0,7,5,0, 1,1,1,7,2);
    for (int k = 0; k < 3; k++) add(0,7,5,0, 1,0,1,7,2);
    add(1,7,0,0, 0,0,0,7,2);
    add(0,7,0,0, 1,1,1,8,2);
    for (int k = 0; k < 7; k++) add(0,7,0,0, 1,0,1,8,2);
    add(0,0,0,0, 0,0,0,8,2);

    reset_n = 1'b0;
    drive(0, 0, 0, 0);
    repeat (3) tick();
    chk("rst window_out", 32'(window_out), 32'(0));
    chk("rst window_start", 32'(window_start), 32'(0));
    chk("rst busy", 32'(busy), 32'(0));
    chk("rst n_accepted", 32'(n_accepted), 32'(0));
    chk("rst n_rejected", 32'(n_rejected), 32'(0));
    reset_n = 1'b1;
    tick();

    foreach (vq[i]) begin
      chk($sformatf("row%0d window_out", i), 32'(window_out), 32'(vq[i].win));
      chk($sformatf("row%0d window_start", i), 32'(window_start), 32'(vq[i].st));
      chk($sformatf("row%0d busy", i), 32'(busy), 32'(vq[i].bsy));
      chk($sformatf("row%0d n_accepted", i), 32'(n_accepted), 32'(vq[i].acc));
      chk($sformatf("row%0d n_rejected", i), 32'(n_rejected), 32'(vq[i].rej));
      drive(vq[i].trig, vq[i].w, vq[i].d, vq[i].clr);
      tick();
    end

    // Continuous trigger with long window/dead: almost every cycle is a reject
    drive(1, 15, 15, 0);
    for (int c = 0; c < 10000 && n_rejected != 12'hFFF; c++) tick();
    chk("rej reaches max", 32'(n_rejected), 32'(4095));
    repeat (64) tick();
    chk("rej saturated", 32'(n_rejected), 32'(4095));

    hit = 1'b0;
    for (int c = 0; c < 64 && !hit; c++) begin
      if (busy) hit = 1'b1;
      else tick();
    end
    chk("busy before clear", 32'(busy), 32'(1));
    drive(1, 15, 15, 1);
    tick();
    drive(0, 15, 15, 0);
    chk("clear rej", 32'(n_rejected), 32'(0));
    chk("clear acc", 32'(n_accepted), 32'(0));
    tick();
    chk("clear rej hold", 32'(n_rejected), 32'(0));

    hit = 1'b0;
    for (int c = 0; c < 64 && !hit; c++) begin
      if (!busy) hit = 1'b1;
      else tick();
    end
    chk("idle before reset test", 32'(busy), 32'(0));
    drive(1, 5, 3, 0);
    tick();
    drive(0, 5, 3, 0);
    chk("pre-rst start", 32'(window_start), 32'(1));
    chk("pre-rst acc", 32'(n_accepted), 32'(1));
    tick();
    chk("pre-rst window", 32'(window_out), 32'(1));
    reset_n = 1'b0;
    #1;
    chk("async rst window_out", 32'(window_out), 32'(0));
    chk("async rst busy", 32'(busy), 32'(0));
    chk("async rst acc", 32'(n_accepted), 32'(0));
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    chk("post-rst window_out", 32'(window_out), 32'(0));
    chk("post-rst busy", 32'(busy), 32'(0));
    drive(1, 1, 0, 0);
    chk("post-rst acc 0", 32'(n_accepted), 32'(0));
    tick();
    drive(0, 1, 0, 0);
    chk("post-rst start", 32'(window_start), 32'(1));
    chk("post-rst acc 1", 32'(n_accepted), 32'(1));
    tick();
    chk("post-rst window 2nd", 32'(window_out), 32'(1));
    tick();
    chk("post-rst window end", 32'(window_out), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
